mult_div_ctrl: RTL
==================

# mult_div_ctrl

Multi-cycle multiply/divide unit controller for the pipelined MIPS CPU, located in the Execute stage. It accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers. It models fixed-latency arithmetic with a busy counter and produces the stall request that holds D-stage HI/LO-related instructions while an operation is pending.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MDOp  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- Start  in  1  E-stage instruction is mult/multu/div/divu (qualifies MDOp 1–4)
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- D_MD  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  operation in progress
- MDStall  out  1  stall request to hazard unit

## Operation
- States: IDLE, MULT, DIV. Down-counter `cnt`, width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE + Start && MDOp∈{1,2}: latch A, B, and signedness. cnt←MULT_CYCLES. Go to MULT.
- IDLE + Start && MDOp∈{3,4}: same latch. cnt←DIV_CYCLES. Go to DIV.
- MULT/DIV: cnt decrements each cycle. When cnt==1, the edge writes the result, sets cnt←0, and returns to IDLE.
- mult: {HI,LO} ← signed 64-bit product. multu: unsigned 64-bit product.
- div: LO ← quotient truncated toward zero. HI ← remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap).
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu, B==0): the full DIV_CYCLES busy period still runs, and HI and LO are left unchanged.
- mthi (MDOp 5) in IDLE: HI←A at this edge. mtlo (MDOp 6) in IDLE: LO←A. Neither asserts Busy.
- Start, mthi or mtlo arriving while not IDLE is ignored. This cannot occur in correct operation because MDStall holds the instruction in D.
- Start with MDOp∉{1..4}: treated as no operation.
- Busy = (state != IDLE).
- MDStall = D_MD && (Start || Busy). This is combinational.
- Operands are latched at start, so A and B may change during the busy period without effect.

## Timing
- Reset: HI=0, LO=0, Busy=0, MDStall=0 when D_MD=0, state IDLE, cnt=0.
- Reset asserted mid-operation aborts the operation. The next cycle shows the reset values, and the result is discarded.
- Start sampled at edge T:
  - Busy=1 during cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO update at the edge closing cycle T+N, so the new values are visible and Busy=0 from cycle T+N+1.
- A D-stage mfhi in cycle T is stalled through cycle T+N. It enters E in cycle T+N+1 and reads the new HI.
- mthi/mtlo: HI/LO visible the cycle after the write edge (latency 1).
- Back-to-back operations: a new Start is accepted in cycle T+N+1 at the earliest.

## Test plan
- mult: A=0xFFFFFFFD (-3), B=5, default params.
  - Busy is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu: A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div: A=0xFFFFFFF9 (-7), B=2.
  - Result: LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
  - With A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu by zero: preload HI=0x1234, LO=0x5678 via mthi/mtlo, then divu A=9, B=0.
  - Busy is high for 10 cycles.
  - HI/LO remain 0x1234/0x5678.
- Hazard:
  - D_MD=1 held while a mult starts: MDStall=1 in the start cycle and in all 5 busy cycles, then 0.
  - A second Start driven during busy is ignored: the result equals the first op's.
  - With D_MD=0, MDStall stays 0 throughout.
- Reset at busy cycle 3 of a div: the next cycle shows Busy=0, HI=LO=0, IDLE. A following mult completes normally.

Source files
------------

// File: rtl/mult_div_ctrl_if.sv
// Execute-stage handshake bundle between the pipeline and the HI/LO
// multiply/divide unit. The pipeline side drives the operation request and
// the D-stage hint; the unit returns HI/LO, Busy and the stall request.
interface mult_div_ctrl_if;
    logic [2:0]  MDOp;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_MD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        MDStall;

    modport master (
        output MDOp, Start, A, B, D_MD,
        input  HI, LO, Busy, MDStall
    );

    modport slave (
        input  MDOp, Start, A, B, D_MD,
        output HI, LO, Busy, MDStall
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO. Arithmetic is modelled
// as a fixed-latency operation: operands are captured at start, a down-counter
// runs the busy period, and the result is written on the last busy edge.
module mult_div_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_ctrl_if.slave   md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]      a_r, b_r;
    logic             sign_r;
    logic [31:0]      hi_r, lo_r;
    logic [31:0]      hi_nxt_s, lo_nxt_s;
    logic             latch_s, sign_nxt_s, done_s;

    // Datapath intermediates
    logic [63:0] ext_a_s, ext_b_s, prod_s;
    logic        neg_a_s, neg_b_s, div_zero_s;
    logic [31:0] mag_a_s, mag_b_s, divisor_s, q_mag_s, r_mag_s, quot_s, rem_s;

    // Fixed-latency arithmetic on the captured operands; divisor is forced to
    // one on divide-by-zero so the result is never X (it is discarded anyway).
    always_comb begin
        ext_a_s    = sign_r ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        ext_b_s    = sign_r ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        prod_s     = ext_a_s * ext_b_s;
        neg_a_s    = sign_r & a_r[31];
        neg_b_s    = sign_r & b_r[31];
        mag_a_s    = neg_a_s ? (32'd0 - a_r) : a_r;
        mag_b_s    = neg_b_s ? (32'd0 - b_r) : b_r;
        div_zero_s = (b_r == 32'd0);
        divisor_s  = div_zero_s ? 32'd1 : mag_b_s;
        q_mag_s    = mag_a_s / divisor_s;
        r_mag_s    = mag_a_s % divisor_s;
        quot_s     = (neg_a_s ^ neg_b_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s      = neg_a_s ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Next-state, counter and HI/LO update decisions
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        sign_nxt_s  = sign_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        done_s      = (cnt_r <= CNT_ONE);
        case (state_r)
            ST_IDLE: begin
                if (md.Start && ((md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU))) begin
                    state_nxt_s = ST_MULT;
                    cnt_nxt_s   = CNT_MULT;
                    latch_s     = 1'b1;
                    sign_nxt_s  = (md.MDOp == OP_MULT);
                end else if (md.Start && ((md.MDOp == OP_DIV) || (md.MDOp == OP_DIVU))) begin
                    state_nxt_s = ST_DIV;
                    cnt_nxt_s   = CNT_DIV;
                    latch_s     = 1'b1;
                    sign_nxt_s  = (md.MDOp == OP_DIV);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                if (md.MDOp == OP_MTHI) begin
                    hi_nxt_s = md.A;
                end else if (md.MDOp == OP_MTLO) begin
                    lo_nxt_s = md.A;
                end else begin
                    hi_nxt_s = hi_r;
                end
            end
            ST_MULT: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    hi_nxt_s    = prod_s[63:32];
                    lo_nxt_s    = prod_s[31:0];
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_DIV: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    if (!div_zero_s) begin
                        hi_nxt_s = rem_s;
                        lo_nxt_s = quot_s;
                    end else begin
                        hi_nxt_s = hi_r;
                    end
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and busy-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Operand capture at start so A/B may change during the busy period
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            sign_r <= 1'b0;
        end else if (latch_s) begin
            a_r    <= md.A;
            b_r    <= md.B;
            sign_r <= sign_nxt_s;
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    assign md.HI      = hi_r;
    assign md.LO      = lo_r;
    assign md.Busy    = (state_r != ST_IDLE);
    assign md.MDStall = md.D_MD && (md.Start || (state_r != ST_IDLE));

endmodule
